// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/busy/done handshake bundle for the sequential multiplier
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, is_signed, m, q,
    input  busy, done, p
  );

  modport slave (
    input  start, is_signed, m, q,
    output busy, done, p
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-and-add multiplier, one partial product per clock
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   qmag;
  logic [2*WIDTH-1:0] mshift;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               done_r;
  logic [2*WIDTH-1:0] p_r;

  logic [WIDTH-1:0]   m_abs;
  logic [WIDTH-1:0]   q_abs;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] result;
  logic               last_step;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    m_abs = bus.m;
    q_abs = bus.q;
    if (bus.is_signed && bus.m[WIDTH-1]) m_abs = ~bus.m + WIDTH'(1);
    if (bus.is_signed && bus.q[WIDTH-1]) q_abs = ~bus.q + WIDTH'(1);
  end

  // Multiplier bits are consumed from qmag[0] while the multiplicand walks left.
  always_comb begin
    addend    = qmag[0] ? mshift : '0;
    result    = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    last_step = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      qmag   <= '0;
      mshift <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            qmag   <= q_abs;
            mshift <= {{WIDTH{1'b0}}, m_abs};
            neg    <= bus.is_signed & (bus.m[WIDTH-1] ^ bus.q[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc + addend;
          mshift <= mshift << 1;
          qmag   <= qmag >> 1;
          count  <= count + CW'(1);
          if (last_step) state <= FIX;
        end
        FIX: begin
          p_r    <= result;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.p    = p_r;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst8 = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  seq_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  seq_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(rst8), .bus(bus8));

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t        sb[2][$];
  logic [15:0] model_p[2];
  bit          en[2];

  // Golden product from integer arithmetic on the operand values.
  function automatic logic [15:0] ref_mul(int w, bit s, logic [7:0] a, logic [7:0] b);
    longint x, y, prod;
    logic [15:0] mask;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    prod = x * y;
    mask = (16'h1 << (2 * w)) - 16'h1;
    return prod[15:0] & mask;
  endfunction

  task automatic step(int id, bit rst, bit st, bit s, logic [7:0] a, logic [7:0] b);
    logic bsy;
    int   w;
    exp_t e;
    @(negedge clk);
    #1;
    if (id == 0) begin
      w = 4;
      rst4 = rst; bus4.start = st; bus4.is_signed = s; bus4.m = a[3:0]; bus4.q = b[3:0];
      bsy = bus4.busy;
    end else begin
      w = 8;
      rst8 = rst; bus8.start = st; bus8.is_signed = s; bus8.m = a; bus8.q = b;
      bsy = bus8.busy;
    end
    if (rst) begin
      sb[id].delete();
      model_p[id] = '0;
      en[id] = 1'b1;
    end else if (st && bsy !== 1'b1) begin
      e.prod = ref_mul(w, s, (w == 4) ? (a & 8'h0F) : a, (w == 4) ? (b & 8'h0F) : b);
      e.due  = edge_cnt + 1 + w + 1;
      sb[id].push_back(e);
    end
  endtask

  task automatic idle_junk(int id, int n);
    for (int i = 0; i < n; i++) step(id, 0, 0, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_one(bit s, logic [7:0] a, logic [7:0] b);
    step(0, 0, 1, s, a, b);
    idle_junk(0, 5);
  endtask

  task automatic mon(int id, logic bsy, logic dn, logic [15:0] pv);
    exp_t e;
    if (!en[id]) return;
    if (dn === 1'b1) begin
      checks++;
      if (sb[id].size() == 0) begin
        errors++;
        $display("FAIL done%0d unexpected pulse at edge %0d", id, edge_cnt);
      end else begin
        e = sb[id].pop_front();
        model_p[id] = e.prod;
        if (edge_cnt != e.due) begin
          errors++;
          $display("FAIL latency%0d done at edge %0d required %0d", id, edge_cnt, e.due);
        end
      end
    end else if (sb[id].size() > 0 && edge_cnt >= sb[id][0].due) begin
      checks++;
      errors++;
      $display("FAIL done%0d missing at edge %0d (due %0d)", id, edge_cnt, sb[id][0].due);
      void'(sb[id].pop_front());
    end
    checks++;
    if (pv !== model_p[id]) begin
      errors++;
      $display("FAIL p%0d got %h required %h at edge %0d", id, pv, model_p[id], edge_cnt);
    end
    checks++;
    if (bsy !== (sb[id].size() > 0)) begin
      errors++;
      $display("FAIL busy%0d got %b required %b at edge %0d", id, bsy, sb[id].size() > 0, edge_cnt);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus4.busy, bus4.done, {8'h00, bus4.p});
    mon(1, bus8.busy, bus8.done, bus8.p);
  end

  task automatic seq4();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle_junk(0, 2);
    run_one(0, 8'd15, 8'd15);
    run_one(1, 8'h08, 8'h08);
    run_one(1, 8'h0D, 8'h05);
    run_one(0, 8'h0D, 8'h05);
    run_one(1, 8'h07, 8'h08);
    run_one(0, 8'h00, 8'h00);
    // Restarts while busy must be ignored.
    step(0, 0, 1, 0, 8'h03, 8'h07);
    step(0, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 1, 8'h0F, 8'h0F);
    step(0, 0, 1, 0, 8'h09, 8'h09);
    idle_junk(0, 5);
    // Reset mid-operation abandons the product.
    step(0, 0, 1, 0, 8'h0B, 8'h0C);
    idle_junk(0, 2);
    step(0, 1, 0, 0, 8'h00, 8'h00);
    idle_junk(0, 2);
    run_one(1, 8'h09, 8'h06);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1'($urandom), 8'($urandom), 8'($urandom));
    idle_junk(0, 6);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_one(1'(s), 8'(a), 8'(b));
    idle_junk(0, 8);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic seq8();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++)
      step(1, 0, ($urandom_range(0, 3) != 0), 1'($urandom), pick8(), pick8());
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus4.start = 1'b0; bus4.is_signed = 1'b0; bus4.m = '0; bus4.q = '0;
    bus8.start = 1'b0; bus8.is_signed = 1'b0; bus8.m = '0; bus8.q = '0;
    en[0] = 1'b0; en[1] = 1'b0;
    model_p[0] = '0; model_p[1] = '0;
    fork
      seq4();
      seq8();
    join
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
